// File: rtl/dram_bus_bridge_if.sv
// Memory-side request/grant bus between the DRAM bridge and the memory system.
// The request fields (req/we/addr/wdata/wmask) flow master->slave. The grant
// and response fields (gnt/rvalid/rdata) flow slave->master.
interface dram_bus_bridge_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata, wmask,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wmask,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dram_bus_bridge.sv
// DRAM bus bridge.
// The CPU data port issues a single-cycle access. This block turns that access
// into a req/gnt + rvalid bus transaction. It stalls the CPU until the
// transaction completes, returns the read data in a register, and flags an
// access that timed out.
module dram_bus_bridge #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cpu_en,
  input  logic        i_cpu_wen,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  input  logic [3:0]  i_cpu_wmask,
  output logic [31:0] o_cpu_rdata,
  output logic        o_cpu_stall,
  output logic        o_cpu_err,
  dram_bus_bridge_if.master mem_bus
);

  // The counter is at least one bit wide, so that TIMEOUT=0 (timeout disabled)
  // still elaborates.
  localparam int unsigned     CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   TO_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit              TO_EN   = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wmask;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [CW-1:0] r_cnt;

  logic          w_capture;
  logic          w_timeout;
  logic          w_to_done;
  logic          w_rd_done;
  logic          w_cnt_sat;

  // The bus address is word-aligned, so the CPU byte offset is not used here.
  logic          w_unused_addr;
  assign w_unused_addr = ^i_cpu_addr[1:0];

  assign w_capture = (r_state == S_IDLE) && i_cpu_en;
  assign w_cnt_sat = (r_cnt == {CW{1'b1}});
  assign w_timeout = TO_EN && (r_cnt == TO_LAST);

  // Next-state decode. A response in RESP takes priority over a timeout that
  // expires in the same cycle.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    w_next    = r_state;
    w_to_done = 1'b0;
    w_rd_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_cpu_en) w_next = S_REQ;
      end
      S_REQ: begin
        if (w_timeout) begin
          w_next    = S_DONE;
          w_to_done = 1'b1;
        end else if (mem_bus.gnt) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (mem_bus.rvalid) begin
          w_next    = S_DONE;
          w_rd_done = 1'b1;
        end else if (w_timeout) begin
          w_next    = S_DONE;
          w_to_done = 1'b1;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register. The asynchronous reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignment, so every register samples its pre-edge inputs.
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Request registers, captured once when an access is accepted in IDLE.
  // They hold the bus fields stable for the rest of the transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_wmask <= 4'b0000;
    end else if (w_capture) begin
      r_we    <= i_cpu_wen;
      r_addr  <= {i_cpu_addr[31:2], 2'b00};
      r_wdata <= i_cpu_wdata;
      r_wmask <= i_cpu_wen ? i_cpu_wmask : 4'b0000;
    end
  end

  // Timeout counter: counts the cycles spent in REQ/RESP and saturates.
  // It is cleared outside the transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (r_state == S_REQ || r_state == S_RESP) begin
      if (!w_cnt_sat) r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  // Read data returned to the CPU. A load gets the bus data or, after a timeout,
  // ERR_DATA. A store leaves the read data untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= 32'h0;
    end else if (!r_we) begin
      if (w_rd_done)      r_rdata <= mem_bus.rdata;
      else if (w_to_done) r_rdata <= ERR_DATA;
    end
  end

  // Error flag: high only in the DONE cycle entered through a timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err <= 1'b0;
    else      r_err <= w_to_done;
  end

  assign o_cpu_stall   = w_capture || (r_state == S_REQ) || (r_state == S_RESP);
  assign o_cpu_rdata   = r_rdata;
  assign o_cpu_err     = r_err;

  assign mem_bus.req   = (r_state == S_REQ);
  assign mem_bus.we    = r_we;
  assign mem_bus.addr  = r_addr;
  assign mem_bus.wdata = r_wdata;
  assign mem_bus.wmask = r_wmask;

endmodule

// File: tb/tb_dram_bus_bridge.sv
// Self-checking bench for dram_bus_bridge.
// Per-cycle vectors cover the load, store, spurious-pulse and back-to-back
// cases. Hand-written sequences cover the timeout, the same-cycle priority
// between completion and timeout, and asynchronous reset.
module tb_dram_bus_bridge;

  localparam int unsigned TO   = 16;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic        cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wmask;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_err;

  dram_bus_bridge_if bus ();

  dram_bus_bridge #(
    .TIMEOUT  (TO),
    .ERR_DATA (ERRD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_cpu_en    (cpu_en),
    .i_cpu_wen   (cpu_wen),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wdata (cpu_wdata),
    .i_cpu_wmask (cpu_wmask),
    .o_cpu_rdata (cpu_rdata),
    .o_cpu_stall (cpu_stall),
    .o_cpu_err   (cpu_err),
    .mem_bus     (bus)
  );

  always #5 clk = ~clk;

  // One clock cycle: the inputs applied, and the outputs expected before the next rising edge.
  typedef struct {
    logic        en;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        gnt;
    logic        rvalid;
    logic [31:0] mrdata;
    logic        x_stall;
    logic        x_req;
    logic        x_we;
    logic [31:0] x_addr;
    logic [3:0]  x_wmask;
    logic [31:0] x_wdata;
    logic [31:0] x_rdata;
    logic        x_err;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;
  int   n;
  logic req_ok;

  function automatic vec_t mk(
    input logic en, input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
    input logic [3:0] wmask, input logic gnt, input logic rvalid, input logic [31:0] mrdata,
    input logic x_stall, input logic x_req, input logic x_we, input logic [31:0] x_addr,
    input logic [3:0] x_wmask, input logic [31:0] x_wdata, input logic [31:0] x_rdata,
    input logic x_err);
    vec_t v;
    v.en = en; v.wen = wen; v.addr = addr; v.wdata = wdata; v.wmask = wmask;
    v.gnt = gnt; v.rvalid = rvalid; v.mrdata = mrdata;
    v.x_stall = x_stall; v.x_req = x_req; v.x_we = x_we; v.x_addr = x_addr;
    v.x_wmask = x_wmask; v.x_wdata = x_wdata; v.x_rdata = x_rdata; v.x_err = x_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_cpu(input logic en, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wmask);
    cpu_en    = en;
    cpu_wen   = wen;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_wmask = wmask;
  endtask

  task automatic drive_bus(input logic gnt, input logic rvalid, input logic [31:0] rdata);
    bus.gnt    = gnt;
    bus.rvalid = rvalid;
    bus.rdata  = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Test 1: load with an immediate grant and rvalid two cycles after the grant.
    vecs.push_back(mk(1,0,32'h8000_0010,0,4'hF, 0,0,0,           1,0, 0,0,0,0, 32'h0,0));
    vecs.push_back(mk(1,0,32'h8000_0010,0,4'hF, 1,0,0,           1,1, 0,32'h8000_0010,4'h0,0, 32'h0,0));
    vecs.push_back(mk(1,0,32'h8000_0010,0,4'hF, 0,0,0,           1,0, 0,0,0,0, 32'h0,0));
    vecs.push_back(mk(1,0,32'h8000_0010,0,4'hF, 0,1,32'h1234_5678, 1,0, 0,0,0,0, 32'h0,0));
    vecs.push_back(mk(1,0,32'h8000_0010,0,4'hF, 0,0,0,           0,0, 0,0,0,0, 32'h1234_5678,0));
    vecs.push_back(mk(0,0,0,0,0,                0,0,0,           0,0, 0,0,0,0, 32'h1234_5678,0));
    // Test 2: unaligned store, grant delayed; the CPU inputs change mid-transaction.
    vecs.push_back(mk(1,1,32'h8000_0006,32'hAABB_0000,4'hC, 0,0,0, 1,0, 0,0,0,0, 32'h1234_5678,0));
    vecs.push_back(mk(1,1,32'h8000_0006,32'hAABB_0000,4'hC, 0,0,0, 1,1, 1,32'h8000_0004,4'hC,32'hAABB_0000, 32'h1234_5678,0));
    vecs.push_back(mk(0,0,32'hFFFF_FFFF,0,4'hF,             0,0,0, 1,1, 1,32'h8000_0004,4'hC,32'hAABB_0000, 32'h1234_5678,0));
    vecs.push_back(mk(0,0,32'hFFFF_FFFF,0,4'hF,             0,0,0, 1,1, 1,32'h8000_0004,4'hC,32'hAABB_0000, 32'h1234_5678,0));
    vecs.push_back(mk(0,0,32'hFFFF_FFFF,0,4'hF,             1,0,0, 1,1, 1,32'h8000_0004,4'hC,32'hAABB_0000, 32'h1234_5678,0));
    vecs.push_back(mk(0,0,0,0,0, 0,1,32'h5555_AAAA, 1,0, 0,0,0,0, 32'h1234_5678,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,             0,0, 0,0,0,0, 32'h1234_5678,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,             0,0, 0,0,0,0, 32'h1234_5678,0));
    // Test 6: spurious gnt/rvalid in IDLE, rvalid in REQ, and both in DONE.
    vecs.push_back(mk(0,0,0,0,0, 1,1,32'h0BAD_0BAD, 0,0, 0,0,0,0, 32'h1234_5678,0));
    vecs.push_back(mk(0,0,0,0,0, 0,1,32'h0BAD_0BAD, 0,0, 0,0,0,0, 32'h1234_5678,0));
    vecs.push_back(mk(1,0,32'h0000_0104,0,4'hF, 0,0,0,             1,0, 0,0,0,0, 32'h1234_5678,0));
    vecs.push_back(mk(1,0,32'h0000_0104,0,4'hF, 0,1,32'h0BAD_0BAD, 1,1, 0,32'h0000_0104,4'h0,0, 32'h1234_5678,0));
    vecs.push_back(mk(1,0,32'h0000_0104,0,4'hF, 1,1,32'h0BAD_0BAD, 1,1, 0,32'h0000_0104,4'h0,0, 32'h1234_5678,0));
    vecs.push_back(mk(1,0,32'h0000_0104,0,4'hF, 0,0,0,             1,0, 0,0,0,0, 32'h1234_5678,0));
    vecs.push_back(mk(1,0,32'h0000_0104,0,4'hF, 0,1,32'hCAFE_F00D, 1,0, 0,0,0,0, 32'h1234_5678,0));
    vecs.push_back(mk(1,0,32'h0000_0104,0,4'hF, 1,1,32'h0BAD_0BAD, 0,0, 0,0,0,0, 32'hCAFE_F00D,0));
    vecs.push_back(mk(0,0,0,0,0,                1,1,32'h0BAD_0BAD, 0,0, 0,0,0,0, 32'hCAFE_F00D,0));
    vecs.push_back(mk(0,0,0,0,0,                0,0,0,             0,0, 0,0,0,0, 32'hCAFE_F00D,0));
    // Test 5: back-to-back loads at minimum latency, with cpu_en held high.
    vecs.push_back(mk(1,0,32'h0000_0200,0,4'h0, 0,0,0,             1,0, 0,0,0,0, 32'hCAFE_F00D,0));
    vecs.push_back(mk(1,0,32'h0000_0200,0,4'h0, 1,0,0,             1,1, 0,32'h0000_0200,4'h0,0, 32'hCAFE_F00D,0));
    vecs.push_back(mk(1,0,32'h0000_0200,0,4'h0, 0,1,32'h1111_1111, 1,0, 0,0,0,0, 32'hCAFE_F00D,0));
    vecs.push_back(mk(1,0,32'h0000_0200,0,4'h0, 0,0,0,             0,0, 0,0,0,0, 32'h1111_1111,0));
    vecs.push_back(mk(1,0,32'h0000_0204,0,4'h0, 0,0,0,             1,0, 0,0,0,0, 32'h1111_1111,0));
    vecs.push_back(mk(1,0,32'h0000_0204,0,4'h0, 1,0,0,             1,1, 0,32'h0000_0204,4'h0,0, 32'h1111_1111,0));
    vecs.push_back(mk(1,0,32'h0000_0204,0,4'h0, 0,1,32'h2222_2222, 1,0, 0,0,0,0, 32'h1111_1111,0));
    vecs.push_back(mk(1,0,32'h0000_0204,0,4'h0, 0,0,0,             0,0, 0,0,0,0, 32'h2222_2222,0));
    vecs.push_back(mk(0,0,0,0,0,                0,0,0,             0,0, 0,0,0,0, 32'h2222_2222,0));

    // Reset state.
    rst = 1'b0;
    drive_cpu(0, 0, 32'h0, 32'h0, 4'h0);
    drive_bus(0, 0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.stall", {31'h0, cpu_stall}, 32'h0);
    check("reset.req",   {31'h0, bus.req},   32'h0);
    check("reset.we",    {31'h0, bus.we},    32'h0);
    check("reset.addr",  bus.addr,           32'h0);
    check("reset.wdata", bus.wdata,          32'h0);
    check("reset.wmask", {28'h0, bus.wmask}, 32'h0);
    check("reset.rdata", cpu_rdata,          32'h0);
    check("reset.err",   {31'h0, cpu_err},   32'h0);
    rst = 1'b1;
    tick();

    // Vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      drive_cpu(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
      drive_bus(vecs[i].gnt, vecs[i].rvalid, vecs[i].mrdata);
      @(negedge clk);
      check($sformatf("vec%0d.stall", i), {31'h0, cpu_stall}, {31'h0, vecs[i].x_stall});
      check($sformatf("vec%0d.req", i),   {31'h0, bus.req},   {31'h0, vecs[i].x_req});
      check($sformatf("vec%0d.rdata", i), cpu_rdata,          vecs[i].x_rdata);
      check($sformatf("vec%0d.err", i),   {31'h0, cpu_err},   {31'h0, vecs[i].x_err});
      if (vecs[i].x_req) begin
        check($sformatf("vec%0d.we", i),    {31'h0, bus.we},    {31'h0, vecs[i].x_we});
        check($sformatf("vec%0d.addr", i),  bus.addr,           vecs[i].x_addr);
        check($sformatf("vec%0d.wmask", i), {28'h0, bus.wmask}, {28'h0, vecs[i].x_wmask});
        check($sformatf("vec%0d.wdata", i), bus.wdata,          vecs[i].x_wdata);
      end
      tick();
    end
    drive_bus(0, 0, 32'h0);

    // Test 3: the grant never arrives, so the access times out after TO cycles in REQ.
    drive_cpu(1, 0, 32'h0000_0300, 32'h0, 4'h0);
    @(negedge clk);
    check("to.idle_stall", {31'h0, cpu_stall}, 32'h1);
    tick();
    n = 0;
    req_ok = 1'b1;
    while (n < 40) begin
      @(negedge clk);
      if (!cpu_stall) break;
      if (!bus.req) req_ok = 1'b0;
      n++;
      tick();
    end
    check("to.req_cycles", n, TO);
    check("to.req_held",   {31'h0, req_ok},  32'h1);
    check("to.done_err",   {31'h0, cpu_err}, 32'h1);
    check("to.done_rdata", cpu_rdata,        ERRD);
    check("to.done_req",   {31'h0, bus.req}, 32'h0);
    tick();
    drive_cpu(0, 0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("to.after_err", {31'h0, cpu_err},   32'h0);
    check("to.after_req", {31'h0, bus.req},   32'h0);
    check("to.after_stall", {31'h0, cpu_stall}, 32'h0);
    tick();

    // A response in the last cycle before the timeout wins over the timeout.
    drive_cpu(1, 0, 32'h0000_0400, 32'h0, 4'h0);
    tick();
    drive_bus(1, 0, 32'h0);
    tick();
    drive_bus(0, 0, 32'h0);
    repeat (14) tick();
    drive_bus(0, 1, 32'h7777_0001);
    @(negedge clk);
    check("edge.last_resp_stall", {31'h0, cpu_stall}, 32'h1);
    tick();
    drive_bus(0, 0, 32'h0);
    @(negedge clk);
    check("edge.done_stall", {31'h0, cpu_stall}, 32'h0);
    check("edge.done_err",   {31'h0, cpu_err},   32'h0);
    check("edge.done_rdata", cpu_rdata,          32'h7777_0001);
    drive_cpu(0, 0, 32'h0, 32'h0, 4'h0);
    tick();

    // Test 4a: reset asserted in REQ drops mem_req without waiting for a clock edge.
    drive_cpu(1, 0, 32'h0000_0500, 32'h0, 4'h0);
    tick();
    @(negedge clk);
    check("rst_req.before", {31'h0, bus.req}, 32'h1);
    #2;
    drive_cpu(0, 0, 32'h0, 32'h0, 4'h0);
    rst = 1'b0;
    #1;
    check("rst_req.req",   {31'h0, bus.req},   32'h0);
    check("rst_req.stall", {31'h0, cpu_stall}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Test 4b: reset asserted in RESP; an rvalid arriving after release is ignored.
    drive_cpu(1, 0, 32'h0000_0600, 32'h0, 4'h0);
    tick();
    drive_bus(1, 0, 32'h0);
    tick();
    drive_bus(0, 0, 32'h0);
    @(negedge clk);
    check("rst_resp.before_stall", {31'h0, cpu_stall}, 32'h1);
    #2;
    drive_cpu(0, 0, 32'h0, 32'h0, 4'h0);
    rst = 1'b0;
    #1;
    check("rst_resp.req",   {31'h0, bus.req},   32'h0);
    check("rst_resp.err",   {31'h0, cpu_err},   32'h0);
    check("rst_resp.stall", {31'h0, cpu_stall}, 32'h0);
    check("rst_resp.rdata", cpu_rdata,          32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    drive_bus(0, 1, 32'h9999_9999);
    repeat (2) tick();
    drive_bus(0, 0, 32'h0);
    @(negedge clk);
    check("rst_resp.late_rdata", cpu_rdata,          32'h0);
    check("rst_resp.late_stall", {31'h0, cpu_stall}, 32'h0);
    check("rst_resp.late_req",   {31'h0, bus.req},   32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
